// File: rtl/core_ctl_pkg.sv
// Shared types and constants for the per-core run-state controller.
package core_ctl_pkg;
  localparam int PC_W    = 16;
  localparam int STALL_W = 3;
  localparam int PC_STEP = 2;

  typedef enum logic [2:0] {
    ASLEEP,
    RUN,
    STALL,
    PAUSED,
    HALTED
  } run_state_t;
endpackage

// File: rtl/core_run_ctl_if.sv
// Control bundle between the top-level wake/pause/stall broadcast and one core's fetch side.
interface core_run_ctl_if #(
  parameter int PC_W    = 16,
  parameter int STALL_W = 3
);
  import core_ctl_pkg::*;

  // pc_passed[PC_W] is a valid qualifier sampled every posedge with no ready/back-pressure:
  // the controller consumes it only when asleep or paused, otherwise it is dropped.
  logic [PC_W:0]      pc_passed;
  logic [STALL_W-1:0] stall_num;
  logic               run_en;
  logic               halt_req;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  logic               awake;
  logic               halted;
  logic               fetch_valid;
  logic [PC_W-1:0]    fetch_pc;
  logic               stalled;
  logic [STALL_W-1:0] stall_left;
  run_state_t         dbg_state;
  logic [7:0]         dbg_core_id;

  modport master (
    output pc_passed, stall_num, run_en, halt_req, redirect_valid, redirect_pc,
    input  awake, halted, fetch_valid, fetch_pc, stalled, stall_left, dbg_state, dbg_core_id
  );

  modport slave (
    input  pc_passed, stall_num, run_en, halt_req, redirect_valid, redirect_pc,
    output awake, halted, fetch_valid, fetch_pc, stalled, stall_left, dbg_state, dbg_core_id
  );
endinterface

// File: rtl/stall_timer.sv
// Stall countdown: load, decrement to zero, clear; done marks the last stall cycle.
module stall_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign count = cnt;
  assign done  = (cnt == W'(1));
endmodule

// File: rtl/core_run_ctl.sv
// Per-core run-state controller: turns wake/pause/stall broadcasts into fetch PC/valid and status.
module core_run_ctl #(
  parameter int PC_W    = 16,
  parameter int STALL_W = 3,
  parameter int CORE_ID = 0
) (
  input logic           clk,
  input logic           rst_n,
  core_run_ctl_if.slave bus
);
  import core_ctl_pkg::*;

  run_state_t         state, state_nx;
  logic [PC_W-1:0]    pc_q, pc_nx, seq_pc, wake_pc;
  logic               awake_q, awake_nx;
  logic               fetch_valid_q, halted_q, stalled_q;
  logic               wake, stall_req;
  logic               timer_load, timer_clear, timer_done;
  logic [STALL_W-1:0] timer_count;

  assign wake      = bus.pc_passed[PC_W];
  assign wake_pc   = bus.pc_passed[PC_W-1:0];
  assign stall_req = (bus.stall_num != '0);
  assign seq_pc    = bus.redirect_valid ? bus.redirect_pc : pc_q + PC_W'(PC_STEP);

  // Conditions are written so an X input falls into the "0" branch (paused / no stall / no halt).
  always_comb begin
    state_nx    = state;
    pc_nx       = pc_q;
    awake_nx    = awake_q;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    case (state)
      ASLEEP: begin
        if (wake) begin
          pc_nx    = wake_pc;
          awake_nx = 1'b1;
          if (bus.run_en) state_nx = RUN;
          else            state_nx = PAUSED;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_nx = HALTED;
        end else if (bus.run_en) begin
          if (stall_req) begin
            state_nx   = STALL;
            timer_load = 1'b1;
          end else begin
            pc_nx = seq_pc;
          end
        end else begin
          state_nx = PAUSED;
          pc_nx    = seq_pc;
        end
      end
      STALL: begin
        if (bus.run_en) begin
          if (timer_done) begin
            if (stall_req) timer_load = 1'b1;
            else           state_nx   = RUN;
          end
        end else begin
          state_nx    = PAUSED;
          timer_clear = 1'b1;
        end
      end
      PAUSED: begin
        if (wake)       pc_nx    = wake_pc;
        if (bus.run_en) state_nx = RUN;
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = ASLEEP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ASLEEP;
      pc_q          <= '0;
      awake_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      state         <= state_nx;
      pc_q          <= pc_nx;
      awake_q       <= awake_nx;
      fetch_valid_q <= (state_nx == RUN);
      halted_q      <= (state_nx == HALTED);
      stalled_q     <= (state_nx == STALL);
    end
  end

  stall_timer #(.W(STALL_W)) u_stall_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .clear    (timer_clear),
    .load_val (bus.stall_num),
    .count    (timer_count),
    .done     (timer_done)
  );

  assign bus.awake       = awake_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_pc    = pc_q;
  assign bus.stalled     = stalled_q;
  assign bus.stall_left  = timer_count;
  assign bus.dbg_state   = state;
  assign bus.dbg_core_id = 8'(CORE_ID);
endmodule

// File: doc/core_run_ctl.md
Name: core_run_ctl

Overview:
- Per-core run-state controller. It is the receiving end of the top-level wake/pause/stall broadcast that the 4-core top drives into each core.
- It consumes the per-core wake vector (valid + start PC), the per-core stall count and the per-core run-enable bit.
- It produces the core's fetch PC/valid and the awake/halted status that the top uses for its global halt decision.
- One instance sits inside each core, between the top-level control wires and the fetch stage.

Parameters:
- PC_W, 16, PC width in bits (byte address; fetch uses pc[PC_W-1:1]).
- STALL_W, 3, width of the stall count input.
- CORE_ID, 0, core index; used only for status/debug tagging, no behavioural effect.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- pc_passed  in  PC_W+1  bit[PC_W] = wake valid, [PC_W-1:0] = start PC.
- stall_num  in  STALL_W  memory-arbitration stall request in cycles; 0 = none.
- run_en  in  1  1 = core allowed to run, 0 = paused by another core.
- halt_req  in  1  execute stage has retired a halt instruction.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  PC_W  branch target.
- awake  out  1  core has been woken at least once since reset.
- halted  out  1  core is in HALTED.
- fetch_valid  out  1  fetch_pc is valid this cycle.
- fetch_pc  out  PC_W  current fetch address.
- stalled  out  1  core is in STALL.
- stall_left  out  STALL_W  remaining stall cycles, including the current cycle.

Behaviour:
- Reset (async, rst_n=0), with all outputs 0:
  - state=ASLEEP, fetch_pc=0, stall_left=0.
  - Deassertion is released synchronously at the next posedge.
- States: ASLEEP, RUN, STALL, PAUSED, HALTED.
- ASLEEP:
  - fetch_valid=0.
  - If pc_passed[PC_W]=1: fetch_pc<=pc_passed[PC_W-1:0], awake<=1, and the next state depends on run_en:
    - run_en=1 -> RUN.
    - run_en=0 -> PAUSED.
  - All other inputs are ignored.
- RUN: fetch_valid=1. Priority, highest first, evaluated at each posedge:
  1. halt_req=1 -> HALTED; fetch_pc is held.
  2. run_en=0 -> PAUSED; fetch_pc<=next PC computed as in rules 4-5.
  3. stall_num!=0 -> STALL; stall_left<=stall_num; fetch_pc is held. The current-cycle fetch is considered not granted.
  4. redirect_valid=1 -> fetch_pc<=redirect_pc.
  5. Otherwise fetch_pc<=fetch_pc+2, wrapping modulo 2^PC_W (0xFFFE -> 0x0000).
- pc_passed[PC_W]=1 while in RUN/STALL/HALTED is ignored and has no effect.
- STALL:
  - fetch_valid=0, stalled=1, fetch_pc is held.
  - redirect_valid is ignored; execute does not redirect during a stall.
  - Each posedge: stall_left<=stall_left-1.
  - When stall_left=1 at the posedge:
    - if stall_num!=0, reload stall_left<=stall_num and stay in STALL;
    - else go to RUN with stall_left<=0.
  - run_en=0 has priority: -> PAUSED, stall_left<=0.
  - halt_req is not possible in STALL; if asserted it is ignored.
- PAUSED:
  - fetch_valid=0, fetch_pc is held.
  - pc_passed[PC_W]=1 reloads fetch_pc from pc_passed (resume at new PC).
  - run_en=1 -> RUN; fetch resumes at fetch_pc the next cycle.
  - Simultaneous pc_passed valid and run_en=1: the new PC is loaded and RUN is entered in the same edge.
- HALTED:
  - Terminal until reset. halted=1, awake stays 1, fetch_valid=0.
- Latency:
  - wake -> first fetch_valid: 1 cycle.
  - run_en rise -> fetch_valid: 1 cycle.
  - A stall of N yields exactly N cycles with fetch_valid=0 when stall_num drops to 0 by the last stall cycle.
- X-safety: inputs that are X are treated as 0, e.g. an uninitialised run_en from the top means paused.
- Reset asserted mid-STALL or mid-RUN returns the block to ASLEEP immediately (async); awake clears.

Decomposition:
- Shared package core_ctl_pkg holds:
  - the run_state_t enum {ASLEEP, RUN, STALL, PAUSED, HALTED};
  - PC_W, STALL_W and the PC increment constant PC_STEP=2.
- One natural sub-module, stall_timer (load/decrement/reload counter with done flag), used by core_run_ctl for the STALL state.

Test Plan:
- Reset then pc_passed={1,16'h0040}, run_en=1 -> awake=1 next cycle; fetch_pc sequence 0x0040, 0x0042, 0x0044 with fetch_valid=1.
- In RUN at fetch_pc=0x0044, stall_num=3 for one cycle then 0 -> stalled=1 for exactly 3 cycles, stall_left 3,2,1, fetch_pc held at 0x0044; then fetch_pc 0x0044, 0x0046.
- run_en=0 in RUN at 0x0100 -> PAUSED, fetch_valid=0. pc_passed={1,16'h0200} while paused, then run_en=1 -> fetch resumes at 0x0200.
- Same-edge halt_req=1, run_en=0, stall_num=6 -> HALTED (halt wins); halted=1, awake=1, and the block stays halted through further pc_passed pulses.
- Start at 0xFFFC with no redirect -> fetch_pc 0xFFFC, 0xFFFE, 0x0000. redirect_valid with redirect_pc=0x1234 -> next fetch_pc=0x1234.
- rst_n pulsed low mid-STALL (stall_left=2) -> all outputs 0 asynchronously; state ASLEEP; ignores stall_num until the next wake.
